// File: rtl/jk_conv_pkg.sv
// rtl/jk_conv_pkg.sv - shared encodings and golden JK next-state function for JK conversion checkers
package jk_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int ERR_SR = 3;
    localparam int ERR_QB = 2;
    localparam int ERR_D  = 1;
    localparam int ERR_T  = 0;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_conv_checker_if.sv
// rtl/jk_conv_checker_if.sv - observed J/K inputs and Q outputs of the JK conversion block
interface jk_conv_checker_if;
    logic j;
    logic k;
    logic qsr;
    logic qb;
    logic qd;
    logic qt;

    modport master (output j, k, qsr, qb, qd, qt);
    modport slave  (input  j, k, qsr, qb, qd, qt);
endinterface

// File: rtl/jk_ref_model.sv
// rtl/jk_ref_model.sv - golden JK register: load re-seeds from an observed Q, step advances its own state
module jk_ref_model
    import jk_conv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic step,
    input  logic q_load,
    input  logic j,
    input  logic k,
    output logic q_ref
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_ref <= 1'b0;
        end else if (load) begin
            q_ref <= jk_next(q_load, j, k);
        end else if (step) begin
            q_ref <= jk_next(q_ref, j, k);
        end
    end

endmodule

// File: rtl/jk_conv_checker.sv
// rtl/jk_conv_checker.sv - self-check stage comparing SR/D/T-derived JK outputs against a golden model
module jk_conv_checker
    import jk_conv_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int SYNC_CYCLES   = 2,
    parameter int STOP_ON_FAULT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    jk_conv_checker_if.slave   obs,
    output logic [3:0]         err,
    output logic               fault,
    output logic               running,
    output logic [CNT_W-1:0]   mis_cnt,
    output logic [CNT_W-1:0]   chk_cnt
);

    localparam int               SC_W      = $clog2(SYNC_CYCLES + 1);
    localparam logic [SC_W-1:0]  SYNC_LAST = SC_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state, state_n;
    logic [SC_W-1:0]   sync_cnt, sync_n;
    logic [3:0]        err_n;
    logic [CNT_W-1:0]  mis_n, chk_n;
    logic              ref_load, ref_step, q_ref, agree;
    logic [3:0]        m;

    jk_ref_model u_ref (
        .clk    (clk),
        .reset  (reset),
        .load   (ref_load),
        .step   (ref_step),
        .q_load (obs.qd),
        .j      (obs.j),
        .k      (obs.k),
        .q_ref  (q_ref)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sync_cnt <= '0;
            err      <= '0;
            mis_cnt  <= '0;
            chk_cnt  <= '0;
        end else begin
            state    <= state_n;
            sync_cnt <= sync_n;
            err      <= err_n;
            mis_cnt  <= mis_n;
            chk_cnt  <= chk_n;
        end
    end

    always_comb begin
        state_n  = state;
        sync_n   = sync_cnt;
        err_n    = err;
        mis_n    = mis_cnt;
        chk_n    = chk_cnt;
        ref_load = 1'b0;
        ref_step = 1'b0;

        m[ERR_SR] = obs.qsr ^ q_ref;
        m[ERR_QB] = obs.qb ^ ~q_ref;
        m[ERR_D]  = obs.qd ^ q_ref;
        m[ERR_T]  = obs.qt ^ q_ref;
        // SR path powers up unreset, so lock only once every path tracks qd
        agree = (obs.qsr == obs.qd) && (obs.qt == obs.qd) && (obs.qb == ~obs.qd);

        if (clr) begin
            state_n = ST_IDLE;
            sync_n  = '0;
            err_n   = '0;
            mis_n   = '0;
            chk_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state_n = ST_SYNC;
                        sync_n  = '0;
                    end
                end
                ST_SYNC: begin
                    ref_load = 1'b1;
                    if (!en) begin
                        state_n = ST_IDLE;
                    end else if (agree) begin
                        sync_n = sync_cnt + SC_W'(1);
                        if (sync_cnt == SYNC_LAST) begin
                            state_n = ST_RUN;
                        end
                    end else begin
                        sync_n = '0;
                    end
                end
                ST_RUN: begin
                    ref_step = 1'b1;
                    err_n    = err | m;
                    if (chk_cnt != CNT_MAX) begin
                        chk_n = chk_cnt + CNT_W'(1);
                    end
                    if (|m) begin
                        if (mis_cnt != CNT_MAX) begin
                            mis_n = mis_cnt + CNT_W'(1);
                        end
                        if (STOP_ON_FAULT != 0) begin
                            state_n = ST_FAULT;
                        end
                    end
                    // a mismatch on the en-falling cycle is still recorded above
                    if (!en) begin
                        state_n = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fault   = (state == ST_FAULT);
    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_jk_conv_checker.sv
// tb/tb_jk_conv_checker.sv - directed bench for jk_conv_checker with three parameterisations on shared stimulus
module tb_jk_conv_checker;

    logic clk = 1'b0;
    logic reset, en, clr;
    always #5 clk = ~clk;

    jk_conv_checker_if obs ();

    logic [3:0] err_a, err_b, err_c;
    logic       fault_a, fault_b, fault_c;
    logic       run_a, run_b, run_c;
    logic [7:0] mis_a, chk_a, mis_b, chk_b;
    logic [2:0] mis_c, chk_c;

    jk_conv_checker #(.CNT_W(8), .SYNC_CYCLES(2), .STOP_ON_FAULT(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .obs(obs),
        .err(err_a), .fault(fault_a), .running(run_a), .mis_cnt(mis_a), .chk_cnt(chk_a)
    );

    jk_conv_checker #(.CNT_W(8), .SYNC_CYCLES(2), .STOP_ON_FAULT(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .obs(obs),
        .err(err_b), .fault(fault_b), .running(run_b), .mis_cnt(mis_b), .chk_cnt(chk_b)
    );

    jk_conv_checker #(.CNT_W(3), .SYNC_CYCLES(2), .STOP_ON_FAULT(0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .obs(obs),
        .err(err_c), .fault(fault_c), .running(run_c), .mis_cnt(mis_c), .chk_cnt(chk_c)
    );

    typedef struct {
        logic j;
        logic k;
        logic q;
        int   chk_a;
        int   chk_c;
    } vec_t;

    vec_t tbl [8];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic j, input logic k, input logic qsr,
                         input logic qb, input logic qd, input logic qt);
        obs.j   = j;
        obs.k   = k;
        obs.qsr = qsr;
        obs.qb  = qb;
        obs.qd  = qd;
        obs.qt  = qt;
    endtask

    task automatic good(input logic j, input logic k, input logic q);
        drive(j, k, q, ~q, q, q);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // q column is the Q the conversion block must present in that cycle
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 2};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 3, 3};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4, 4};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 5, 5};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 6, 6};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 7, 7};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8, 7};

        reset = 1'b0; en = 1'b0; clr = 1'b0;
        good(1'b0, 1'b0, 1'b0);
        tick; tick;
        check("rst_err",   32'(err_a),   32'h0);
        check("rst_fault", 32'(fault_a), 32'h0);
        check("rst_run",   32'(run_a),   32'h0);
        check("rst_mis",   32'(mis_a),   32'h0);
        check("rst_chk",   32'(chk_a),   32'h0);
        reset = 1'b1;

        en = 1'b1;
        tick; check("sync_e1_run", 32'(run_a), 32'h0);
        tick; check("sync_e2_run", 32'(run_a), 32'h0);
        tick; check("sync_e3_run", 32'(run_a), 32'h1);

        for (int i = 0; i < 8; i++) begin
            good(tbl[i].j, tbl[i].k, tbl[i].q);
            tick;
            check($sformatf("t1_err_%0d", i), 32'(err_a), 32'h0);
            check($sformatf("t1_mis_%0d", i), 32'(mis_a), 32'h0);
            check($sformatf("t1_chk_%0d", i), 32'(chk_a), 32'(tbl[i].chk_a));
            check($sformatf("t1_run_%0d", i), 32'(run_a), 32'h1);
            check($sformatf("t1_chkc_%0d", i), 32'(chk_c), 32'(tbl[i].chk_c));
        end

        // drive q_ref to 1, then break the T path for one cycle
        good(1'b1, 1'b0, 1'b0);
        tick;
        check("t2_pre_chk", 32'(chk_a), 32'd9);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        check("t2_err_a",   32'(err_a),   32'h1);
        check("t2_fault_a", 32'(fault_a), 32'h1);
        check("t2_run_a",   32'(run_a),   32'h0);
        check("t2_mis_a",   32'(mis_a),   32'h1);
        check("t2_chk_a",   32'(chk_a),   32'd10);
        check("t2_run_b",   32'(run_b),   32'h1);
        check("t2_fault_b", 32'(fault_b), 32'h0);
        check("t2_chk_c",   32'(chk_c),   32'd7);
        good(1'b0, 1'b0, 1'b1);
        tick; tick;
        check("t2_frz_chk_a", 32'(chk_a), 32'd10);
        check("t2_frz_flt_a", 32'(fault_a), 32'h1);
        check("t2_chk_b",     32'(chk_b), 32'd12);

        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("clr_fault_a", 32'(fault_a), 32'h0);
        check("clr_err_a",   32'(err_a),   32'h0);
        check("clr_chk_a",   32'(chk_a),   32'h0);
        check("clr_mis_a",   32'(mis_a),   32'h0);
        check("clr_chk_c",   32'(chk_c),   32'h0);
        check("clr_run_b",   32'(run_b),   32'h0);

        // SR path stuck high while qd=0: must not lock
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) tick;
        check("t4_nolock", 32'(run_a), 32'h0);
        good(1'b0, 1'b0, 1'b0);
        tick; check("t4_agree1", 32'(run_a), 32'h0);
        tick; check("t4_agree2", 32'(run_a), 32'h1);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            tick;
        end
        check("t3_err_a",   32'(err_a),   32'h2);
        check("t3_fault_a", 32'(fault_a), 32'h1);
        check("t3_mis_a",   32'(mis_a),   32'h1);
        check("t3_chk_a",   32'(chk_a),   32'h1);
        check("t3_err_b",   32'(err_b),   32'h2);
        check("t3_mis_b",   32'(mis_b),   32'd3);
        check("t3_run_b",   32'(run_b),   32'h1);
        check("t3_chk_b",   32'(chk_b),   32'd5);
        check("t3_mis_c",   32'(mis_c),   32'd3);

        good(1'b0, 1'b0, 1'b0);
        repeat (5) tick;
        check("t5_sat_c", 32'(chk_c), 32'd7);
        check("t5_chk_b", 32'(chk_b), 32'd10);

        // en falls on a mismatching RUN cycle
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        check("enfall_mis_b", 32'(mis_b), 32'd4);
        check("enfall_chk_b", 32'(chk_b), 32'd11);
        check("enfall_run_b", 32'(run_b), 32'h0);
        check("enfall_err_b", 32'(err_b), 32'h2);
        check("enfall_chk_c", 32'(chk_c), 32'd7);
        check("fault_hold_a", 32'(fault_a), 32'h1);
        check("fault_mis_a",  32'(mis_a), 32'h1);

        clr = 1'b1;
        good(1'b0, 1'b0, 1'b0);
        tick;
        clr = 1'b0;
        check("t5_clr_chk_c", 32'(chk_c), 32'h0);
        check("t5_clr_err_b", 32'(err_b), 32'h0);
        check("t5_clr_flt_a", 32'(fault_a), 32'h0);

        en = 1'b1;
        repeat (3) tick;
        check("resync_run_a", 32'(run_a), 32'h1);
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        clr = 1'b0;
        check("clrmis_err_a", 32'(err_a), 32'h0);
        check("clrmis_mis_a", 32'(mis_a), 32'h0);
        check("clrmis_chk_a", 32'(chk_a), 32'h0);
        check("clrmis_run_a", 32'(run_a), 32'h0);

        good(1'b0, 1'b0, 1'b0);
        repeat (3) tick;
        check("t6_run_a", 32'(run_a), 32'h1);
        tick;
        check("t6_chk_a", 32'(chk_a), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_run", 32'(run_a), 32'h0);
        check("t6_async_chk", 32'(chk_a), 32'h0);
        check("t6_async_chkb", 32'(chk_b), 32'h0);
        tick;
        reset = 1'b1;
        tick;
        check("t6_rel_e1_run", 32'(run_a), 32'h0);
        check("t6_rel_e1_chk", 32'(chk_a), 32'h0);
        tick;
        check("t6_rel_e2_run", 32'(run_a), 32'h0);
        tick;
        check("t6_rel_e3_run", 32'(run_a), 32'h1);
        tick;
        check("t6_rel_chk", 32'(chk_a), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
